// File: rtl/id_ex_stage_pkg.sv
// +----------------------------------------------------------------------------+
// | Package   : ex_pkg                                                        |
// | Purpose   : ALU control codes, ALU op enum, funct3 codes and the ID/EX     |
// |             control-field record shared by the ID/EX stage.               |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package ex_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        AOP_MEM = 2'b00,
        AOP_BR  = 2'b01,
        AOP_R   = 2'b10,
        AOP_I   = 2'b11
    } alu_op_t;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Width-independent stage fields; data/index fields live in the stage
    // itself because their widths follow the stage parameters.
    typedef struct packed {
        logic     valid;
        logic     reg_write;
        logic     alu_src;
        alu_op_t  alu_op;
        logic [2:0] funct3;
        logic     funct7_b5;
    } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// +----------------------------------------------------------------------------+
// | Module    : alu_ctrl_dec                                                  |
// | Purpose   : Combinational alu_op/funct3/funct7_b5 -> 4-bit ALU control.   |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_ctrl_dec
    import ex_pkg::*;
(
    input  logic       valid,
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        if (valid) begin
            case (alu_op)
                AOP_MEM: alu_control = ALU_ADD;
                AOP_BR:  alu_control = ALU_SUB;
                default: begin
                    case (funct3)
                        // Only R-type uses bit 30 to pick SUB; I-type ADDI ignores it.
                        F3_ADD_SUB: alu_control = (alu_op == AOP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
                        F3_AND:     alu_control = ALU_AND;
                        F3_OR:      alu_control = ALU_OR;
                        F3_XOR:     alu_control = ALU_XOR;
                        default:    alu_control = ALU_ADD;
                    endcase
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// +----------------------------------------------------------------------------+
// | Module    : id_ex_stage                                                   |
// | Purpose   : ID/EX pipeline register with RAW forwarding and ALU operand   |
// |             select. Define EX_FORWARD_EN to enable EX/MEM, MEM/WB bypass. |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module id_ex_stage
    import ex_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int RADDR_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [REG_WIDTH-1:0] id_rs1_data,
    input  logic [REG_WIDTH-1:0] id_rs2_data,
    input  logic [REG_WIDTH-1:0] id_imm,
    input  logic [RADDR_W-1:0]   id_rs1,
    input  logic [RADDR_W-1:0]   id_rs2,
    input  logic [RADDR_W-1:0]   id_rd,
    input  logic                 id_alu_src,
    input  logic [1:0]           id_alu_op,
    input  logic [2:0]           id_funct3,
    input  logic                 id_funct7_b5,
    input  logic                 id_reg_write,
    input  logic                 exmem_reg_write,
    input  logic [RADDR_W-1:0]   exmem_rd,
    input  logic [REG_WIDTH-1:0] exmem_result,
    input  logic                 memwb_reg_write,
    input  logic [RADDR_W-1:0]   memwb_rd,
    input  logic [REG_WIDTH-1:0] memwb_result,
    output logic [REG_WIDTH-1:0] alu_in1,
    output logic [REG_WIDTH-1:0] alu_in2,
    output logic [3:0]           alu_control,
    output logic                 ex_valid,
    output logic [RADDR_W-1:0]   ex_rd,
    output logic                 ex_reg_write,
    output logic [REG_WIDTH-1:0] ex_store_data
);

    id_ex_t               ctrl_q;
    logic [REG_WIDTH-1:0] rs1_data_q;
    logic [REG_WIDTH-1:0] rs2_data_q;
    logic [REG_WIDTH-1:0] imm_q;
    logic [RADDR_W-1:0]   rs1_q;
    logic [RADDR_W-1:0]   rs2_q;
    logic [RADDR_W-1:0]   rd_q;
    // Marks the post-reset state so the ALU sees AND (0000) rather than the
    // bubble default of ADD until the first real update.
    logic                 fresh_q;

    logic [REG_WIDTH-1:0] fwd_a;
    logic [REG_WIDTH-1:0] fwd_b;
    logic [3:0]           dec_control;
    logic                 zero_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            fresh_q    <= 1'b1;
        end else if (flush) begin
            ctrl_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            fresh_q    <= 1'b0;
        end else if (!stall) begin
            ctrl_q.valid     <= id_valid;
            ctrl_q.reg_write <= id_reg_write;
            ctrl_q.alu_src   <= id_alu_src;
            ctrl_q.alu_op    <= alu_op_t'(id_alu_op);
            ctrl_q.funct3    <= id_funct3;
            ctrl_q.funct7_b5 <= id_funct7_b5;
            rs1_data_q       <= id_rs1_data;
            rs2_data_q       <= id_rs2_data;
            imm_q            <= id_imm;
            rs1_q            <= id_rs1;
            rs2_q            <= id_rs2;
            rd_q             <= id_rd;
            fresh_q          <= 1'b0;
        end
    end

`ifdef EX_FORWARD_EN
    always_comb begin
        fwd_a = rs1_data_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs1_q)
            fwd_a = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs1_q)
            fwd_a = memwb_result;
    end

    always_comb begin
        fwd_b = rs2_data_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs2_q)
            fwd_b = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs2_q)
            fwd_b = memwb_result;
    end
`else
    // Without bypass the hazard unit stalls on RAW; forwarding ports are ignored.
    logic unused_fwd;
    assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result, rs1_q, rs2_q};
    assign fwd_a = rs1_data_q;
    assign fwd_b = rs2_data_q;
`endif

    alu_ctrl_dec u_alu_ctrl_dec (
        .valid       (ctrl_q.valid),
        .alu_op      (ctrl_q.alu_op),
        .funct3      (ctrl_q.funct3),
        .funct7_b5   (ctrl_q.funct7_b5),
        .alu_control (dec_control)
    );

    assign zero_out      = reset | fresh_q;
    assign alu_in1       = zero_out ? '0 : fwd_a;
    assign alu_in2       = zero_out ? '0 : (ctrl_q.alu_src ? imm_q : fwd_b);
    assign ex_store_data = zero_out ? '0 : fwd_b;
    assign alu_control   = zero_out ? ALU_AND : dec_control;
    assign ex_valid      = ~zero_out & ctrl_q.valid;
    assign ex_rd         = zero_out ? '0 : rd_q;
    assign ex_reg_write  = ~zero_out & ctrl_q.reg_write & ctrl_q.valid;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// +----------------------------------------------------------------------------+
// | Module    : tb_id_ex_stage                                                |
// | Purpose   : Self-checking bench for id_ex_stage against a reference model.|
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_stage;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_alu_src;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_funct7_b5, id_reg_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]  alu_control;
    logic        ex_valid, ex_reg_write;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.REG_WIDTH(32), .RADDR_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_funct3(id_funct3),
        .id_funct7_b5(id_funct7_b5), .id_reg_write(id_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_store_data(ex_store_data)
    );

    // Reference model: the instruction currently held by EX, as a record.
    typedef struct {
        bit        valid, rw, src, f7;
        bit [1:0]  op;
        bit [2:0]  f3;
        bit [31:0] d1, d2, imm;
        bit [4:0]  rs1, rs2, rd;
    } instr_t;

    instr_t m_ins;
    bit     m_fresh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] bypass(input bit [4:0] rs, input bit [31:0] rf);
        if (FWD && exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
        if (FWD && memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
        return rf;
    endfunction

    function automatic bit [3:0] ctrl_of(input instr_t i);
        if (!i.valid) return 4'b0010;
        if (i.op == 2'b00) return 4'b0010;
        if (i.op == 2'b01) return 4'b0110;
        case (i.f3)
            3'b000:  return (i.op == 2'b10 && i.f7) ? 4'b0110 : 4'b0010;
            3'b111:  return 4'b0000;
            3'b110:  return 4'b0001;
            3'b100:  return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic instr_t capture_id();
        instr_t i;
        i.valid = id_valid;  i.rw = id_reg_write; i.src = id_alu_src; i.f7 = id_funct7_b5;
        i.op = id_alu_op;    i.f3 = id_funct3;
        i.d1 = id_rs1_data;  i.d2 = id_rs2_data;  i.imm = id_imm;
        i.rs1 = id_rs1;      i.rs2 = id_rs2;      i.rd = id_rd;
        return i;
    endfunction

    task automatic tick();
        instr_t bubble;
        bubble = '{default: 0};
        @(posedge clk);
        if (reset) begin
            m_ins = bubble; m_fresh = 1'b1;
        end else if (flush) begin
            m_ins = bubble; m_fresh = 1'b0;
        end else if (!stall) begin
            m_ins = capture_id(); m_fresh = 1'b0;
        end
        #1;
    endtask

    task automatic check_now();
        bit        z;
        bit [31:0] a, b;
        z = reset || m_fresh;
        a = bypass(m_ins.rs1, m_ins.d1);
        b = bypass(m_ins.rs2, m_ins.d2);
        chk("alu_in1",       alu_in1,       z ? 32'd0 : a);
        chk("alu_in2",       alu_in2,       z ? 32'd0 : (m_ins.src ? m_ins.imm : b));
        chk("store_data",    ex_store_data, z ? 32'd0 : b);
        chk("alu_control",   {28'd0, alu_control}, z ? 32'd0 : {28'd0, ctrl_of(m_ins)});
        chk("ex_valid",      {31'd0, ex_valid},    {31'd0, !z && m_ins.valid});
        chk("ex_rd",         {27'd0, ex_rd},       z ? 32'd0 : {27'd0, m_ins.rd});
        chk("ex_reg_write",  {31'd0, ex_reg_write}, {31'd0, !z && m_ins.valid && m_ins.rw});
    endtask

    task automatic check_cycle();
        @(negedge clk);
        check_now();
    endtask

    task automatic rand_id();
        id_valid     = 1'($urandom);
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_imm       = $urandom;
        id_rs1       = 5'($urandom_range(0, 3));
        id_rs2       = 5'($urandom_range(0, 3));
        id_rd        = 5'($urandom);
        id_alu_src   = 1'($urandom);
        id_alu_op    = 2'($urandom);
        id_funct3    = 3'($urandom);
        id_funct7_b5 = 1'($urandom);
        id_reg_write = 1'($urandom);
    endtask

    task automatic rand_fwd();
        exmem_reg_write = 1'($urandom);
        exmem_rd        = 5'($urandom_range(0, 3));
        exmem_result    = $urandom;
        memwb_reg_write = 1'($urandom);
        memwb_rd        = 5'($urandom_range(0, 3));
        memwb_result    = $urandom;
    endtask

    task automatic set_id(input bit [1:0] op, input bit [2:0] f3, input bit f7, input bit src,
                          input bit [4:0] rs1, input bit [4:0] rs2,
                          input bit [31:0] d1, input bit [31:0] d2, input bit [31:0] imm);
        id_valid = 1'b1; id_reg_write = 1'b1; id_rd = 5'd9;
        id_alu_op = op; id_funct3 = f3; id_funct7_b5 = f7; id_alu_src = src;
        id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    initial begin
        logic [31:0] frozen_in1, frozen_in2;
        m_ins = '{default: 0};
        m_fresh = 1'b0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        rand_id();
        rand_fwd();

        // Reset for two cycles, then the idle cycle after it.
        tick(); check_cycle();
        tick(); check_cycle();
        reset = 1'b0;
        check_now();
        chk("reset_ctrl", {28'd0, alu_control}, 32'd0);
        chk("reset_valid", {31'd0, ex_valid}, 32'd0);

        // R-type SUB, no hazards.
        no_fwd();
        set_id(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 32'd10, 32'd3, 32'd0);
        tick(); check_cycle();
        chk("sub_in1", alu_in1, 32'd10);
        chk("sub_in2", alu_in2, 32'd3);
        chk("sub_ctrl", {28'd0, alu_control}, 32'h6);

        // Forward priority on rs1 = 5.
        set_id(2'b10, 3'b111, 1'b0, 1'b0, 5'd5, 5'd6, 32'h11, 32'h22, 32'd0);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAA;
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hBB;
        check_cycle();
        chk("fwd_both", alu_in1, FWD ? 32'hAA : 32'h11);
        exmem_reg_write = 1'b0;
        #1;
        check_now();
        chk("fwd_memwb", alu_in1, FWD ? 32'hBB : 32'h11);

        // x0 is never bypassed.
        no_fwd();
        set_id(2'b10, 3'b110, 1'b0, 1'b0, 5'd1, 5'd0, 32'h5, 32'h0, 32'd0);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h55;
        check_cycle();
        chk("x0_guard", alu_in2, 32'h0);

        // I-type XOR with immediate; store data still carries bypassed rs2.
        no_fwd();
        set_id(2'b11, 3'b100, 1'b1, 1'b1, 5'd2, 5'd3, 32'h1, 32'h77, 32'hF0);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h99;
        check_cycle();
        chk("xori_in2", alu_in2, 32'hF0);
        chk("xori_ctrl", {28'd0, alu_control}, 32'h3);
        chk("xori_store", ex_store_data, FWD ? 32'h99 : 32'h77);

        // Stall three cycles with changing ID fields: outputs frozen.
        no_fwd();
        set_id(2'b00, 3'b010, 1'b0, 1'b0, 5'd1, 5'd2, 32'h1234, 32'h5678, 32'd4);
        tick(); check_cycle();
        frozen_in1 = alu_in1;
        frozen_in2 = alu_in2;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_id();
            tick(); check_cycle();
            chk("stall_in1", alu_in1, 32'h1234);
            chk("stall_in2", alu_in2, 32'h5678);
        end
        if (frozen_in1 !== 32'h1234 || frozen_in2 !== 32'h5678)
            $display("NOTE pre-stall operands differ from loaded values");

        // Stall and flush together: flush wins.
        flush = 1'b1;
        id_valid = 1'b1; id_reg_write = 1'b1;
        tick(); check_cycle();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Reset asserted while stalled: reset wins.
        set_id(2'b01, 3'b000, 1'b0, 1'b0, 5'd1, 5'd1, 32'h3, 32'h3, 32'd0);
        tick();
        stall = 1'b1; reset = 1'b1;
        tick(); reset = 1'b0; check_cycle();
        chk("rst_stall_valid", {31'd0, ex_valid}, 32'd0);
        stall = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            rand_id();
            tick();
            rand_fwd();
            check_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
